spi_flash_reader: RTL

Wishbone B3 slave that fetches bytes from an external serial flash by acting as SPI master (mode 0, MSB first) and issuing READ (0x03) + 24-bit address. It is the initiator counterpart of the SPI flash/memory responder used in simulation and on boards. It sits between the CPU/boot bus and the flash pins. Sequential reads reuse an open transfer: ss_o is held low and the command/address phases are skipped.

---
 rtl/spi_flash_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - Wishbone read-only bridge to an SPI NOR flash (READ 0x03, mode 0)
`timescale 1ns/1ps
module spi_flash_reader #(
  parameter int CLK_DIV      = 2,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [23:0] wb_adr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        sck_o,
  output logic        ss_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic        busy_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(2 * CLK_DIV);
  localparam int HW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [7:0] READ_CMD = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_ACK, ST_HOLD, ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [30:0]   sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    dat_q, dat_d;
  logic [23:0]   cur_adr_q, cur_adr_d;
  logic [23:0]   last_adr_q, last_adr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sck_q, sck_d, ss_q, ss_d, mosi_q, mosi_d;
  logic          ack_q, ack_d, err_q, err_d;

  logic req, rd_req, wr_req, seq, tick, rise, fall, start, resume;

  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign rd_req = req & ~wb_we_i;
  assign wr_req = req & wb_we_i;
  assign seq    = (wb_adr_i == last_adr_q + 24'd1);
  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign rise   = tick & ~sck_q;
  assign fall   = tick & sck_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      dat_q      <= '0;
      cur_adr_q  <= '0;
      last_adr_q <= '0;
      hold_q     <= '0;
      gap_q      <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      dat_q      <= dat_d;
      cur_adr_q  <= cur_adr_d;
      last_adr_q <= last_adr_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    dat_d      = dat_q;
    cur_adr_d  = cur_adr_q;
    last_adr_d = last_adr_q;
    hold_d     = hold_q;
    gap_d      = gap_q;
    sck_d      = sck_q;
    ss_d       = ss_q;
    mosi_d     = mosi_q;
    ack_d      = 1'b0;
    err_d      = wr_req;
    start      = 1'b0;
    resume     = 1'b0;

    // Half-period engine shared by every shifting state
    if (state_q inside {ST_CMD, ST_ADDR, ST_DATA}) begin
      div_d = tick ? '0 : div_q + 1'b1;
      sck_d = sck_q ^ tick;
    end

    case (state_q)
      ST_IDLE: start = rd_req;
      ST_CMD, ST_ADDR: begin
        if (fall) begin
          sh_d   = {sh_q[29:0], 1'b0};
          mosi_d = sh_q[30];
          bit_d  = bit_q + 1'b1;
          if (state_q == ST_CMD && bit_q == 5'd7) state_d = ST_ADDR;
          if (state_q == ST_ADDR && bit_q == 5'd31) begin
            state_d = ST_DATA;
            mosi_d  = 1'b0;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (rise) rx_d = {rx_q[6:0], miso_i};
        if (fall) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 5'd7) begin
            state_d    = ST_ACK;
            ack_d      = 1'b1;
            dat_d      = rx_q;
            last_adr_d = cur_adr_q;
            hold_d     = '0;
            bit_d      = '0;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
        hold_d  = hold_q + 1'b1;
      end
      ST_HOLD: begin
        // Timeout wins over a request arriving on the same edge
        if (hold_q >= HW'(IDLE_TIMEOUT - 1)) begin
          state_d = ST_GAP;
          ss_d    = 1'b1;
          gap_d   = '0;
        end else if (rd_req && seq) begin
          resume = 1'b1;
        end else if (rd_req) begin
          state_d = ST_GAP;
          ss_d    = 1'b1;
          gap_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(2 * CLK_DIV - 1)) begin
          state_d = ST_IDLE;
          start   = rd_req;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = ST_CMD;
      sh_d      = {READ_CMD[6:0], wb_adr_i};
      cur_adr_d = wb_adr_i;
      mosi_d    = READ_CMD[7];
      ss_d      = 1'b0;
      sck_d     = 1'b0;
      div_d     = '0;
      bit_d     = '0;
    end
    if (resume) begin
      state_d   = ST_DATA;
      cur_adr_d = wb_adr_i;
      mosi_d    = 1'b0;
      sck_d     = 1'b0;
      div_d     = '0;
      bit_d     = '0;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign sck_o    = sck_q;
  assign ss_o     = ss_q;
  assign mosi_o   = mosi_q;
  assign busy_o   = ~ss_q | (state_q == ST_GAP);

endmodule
